// File: rtl/chattering_pkg.sv
// rtl/chattering_pkg.sv - shared constants, hold-state type and width helper for the debouncer
package chattering_pkg;

  localparam int DB_CYC_1MS_32M   = 31999;
  localparam int TICK_DIV_1MS_32M = 32000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  // Bits needed to hold values 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/chattering_ch.sv
// rtl/chattering_ch.sv - one debounced channel: synchroniser, stability counter, edge pulses, hold FSM
module chattering_ch
  import chattering_pkg::*;
#(
  parameter logic IDLE_VAL   = 1'b1,
  parameter int   DB_CYC     = DB_CYC_1MS_32M,
  parameter int   LONG_TICKS = 1000,
  parameter int   REP_TICKS  = 200
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_sw,
  output logic o_sw_out,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse,
  output logic o_repeat_pulse
);

  localparam int CW = clog2(DB_CYC + 1);
  localparam int HW = clog2(((LONG_TICKS > REP_TICKS) ? LONG_TICKS : REP_TICKS) + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DB_CYC);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REP_TICKS > 0) ? REP_TICKS - 1 : 0);

  logic          r_s1;
  logic          r_s2;
  logic          r_sd;
  logic [CW-1:0] r_cnt;
  logic          r_sw_out;
  logic          r_press;
  logic          r_release;
  logic          w_stable;
  logic          w_next_out;
  logic          w_press_ev;
  logic          w_release_ev;

  assign w_stable     = (r_cnt == CNT_MAX);
  assign w_next_out   = w_stable ? r_sd : r_sw_out;
  assign w_press_ev   = (w_next_out != IDLE_VAL) && (r_sw_out == IDLE_VAL);
  assign w_release_ev = (w_next_out == IDLE_VAL) && (r_sw_out != IDLE_VAL);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1      <= IDLE_VAL;
      r_s2      <= IDLE_VAL;
      r_sd      <= IDLE_VAL;
      r_cnt     <= '0;
      r_sw_out  <= IDLE_VAL;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
      r_sd <= r_s2;
      if (r_s2 != r_sd) begin
        r_cnt <= '0;
      end else if (!w_stable) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_sw_out  <= w_next_out;
      r_press   <= w_press_ev;
      r_release <= w_release_ev;
    end
  end

  hold_state_t   r_state;
  hold_state_t   w_state_nxt;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_cnt_nxt;
  logic          r_long;
  logic          r_repeat;
  logic          w_long_set;
  logic          w_repeat_set;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_long     <= w_long_set;
      r_repeat   <= w_repeat_set;
    end
  end

  // Release wins over a coincident tick, so no pulse escapes on the release edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (w_press_ev) begin
          w_state_nxt    = HOLD;
          w_hold_cnt_nxt = '0;
        end
      end
      HOLD: begin
        if (w_release_ev) begin
          w_state_nxt = IDLE;
        end else if (i_tick) begin
          if (r_hold_cnt == LONG_LAST) begin
            w_state_nxt    = REPEAT;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HW'(1);
          end
        end
      end
      REPEAT: begin
        if (w_release_ev) begin
          w_state_nxt = IDLE;
        end else if (i_tick && (REP_TICKS > 0)) begin
          if (r_hold_cnt == REP_LAST) begin
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HW'(1);
          end
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_long_set   = (r_state == HOLD) && !w_release_ev && i_tick && (r_hold_cnt == LONG_LAST);
    w_repeat_set = (r_state == REPEAT) && !w_release_ev && i_tick && (REP_TICKS > 0)
                   && (r_hold_cnt == REP_LAST);
  end

  assign o_sw_out        = r_sw_out;
  assign o_press_pulse   = r_press;
  assign o_release_pulse = r_release;
  assign o_long_pulse    = r_long;
  assign o_repeat_pulse  = r_repeat;

endmodule

// File: rtl/chattering_cut_multi.sv
// rtl/chattering_cut_multi.sv - multi-channel debouncer top: shared hold-tick prescaler and channel array
module chattering_cut_multi
  import chattering_pkg::*;
#(
  parameter int   N_CH       = 4,
  parameter logic IDLE_VAL   = 1'b1,
  parameter int   DB_CYC     = DB_CYC_1MS_32M,
  parameter int   TICK_DIV   = TICK_DIV_1MS_32M,
  parameter int   LONG_TICKS = 1000,
  parameter int   REP_TICKS  = 200
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_sw_in,
  output logic [N_CH-1:0] o_sw_out,
  output logic [N_CH-1:0] o_press_pulse,
  output logic [N_CH-1:0] o_release_pulse,
  output logic [N_CH-1:0] o_long_pulse,
  output logic [N_CH-1:0] o_repeat_pulse
);

  localparam int PW = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic          w_tick;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    chattering_ch #(
      .IDLE_VAL  (IDLE_VAL),
      .DB_CYC    (DB_CYC),
      .LONG_TICKS(LONG_TICKS),
      .REP_TICKS (REP_TICKS)
    ) u_ch (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_tick         (w_tick),
      .i_sw           (i_sw_in[g]),
      .o_sw_out       (o_sw_out[g]),
      .o_press_pulse  (o_press_pulse[g]),
      .o_release_pulse(o_release_pulse[g]),
      .o_long_pulse   (o_long_pulse[g]),
      .o_repeat_pulse (o_repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_chattering_cut_multi.sv
// tb/tb_chattering_cut_multi.sv - self-checking bench for chattering_cut_multi
module tb_chattering_cut_multi;

  localparam int   N_CH = 4;
  localparam logic IDLE = 1'b1;
  localparam int   DB   = 10;
  localparam int   TD   = 4;
  localparam int   LT   = 3;
  localparam int   RT   = 2;
  localparam int   HLEN = DB + 4;
  localparam logic [N_CH-1:0] ALL_IDLE = {N_CH{IDLE}};
  localparam logic [5*N_CH-1:0] RESET_VEC = {ALL_IDLE, {(4*N_CH){1'b0}}};

  logic            clk = 1'b0;
  logic            i_rst;
  logic [N_CH-1:0] i_sw_in;
  logic [N_CH-1:0] o_sw_out;
  logic [N_CH-1:0] o_press_pulse;
  logic [N_CH-1:0] o_release_pulse;
  logic [N_CH-1:0] o_long_pulse;
  logic [N_CH-1:0] o_repeat_pulse;

  chattering_cut_multi #(
    .N_CH      (N_CH),
    .IDLE_VAL  (IDLE),
    .DB_CYC    (DB),
    .TICK_DIV  (TD),
    .LONG_TICKS(LT),
    .REP_TICKS (RT)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_sw_in        (i_sw_in),
    .o_sw_out       (o_sw_out),
    .o_press_pulse  (o_press_pulse),
    .o_release_pulse(o_release_pulse),
    .o_long_pulse   (o_long_pulse),
    .o_repeat_pulse (o_repeat_pulse)
  );

  always #5 clk = ~clk;

  wire [5*N_CH-1:0] obs = {o_sw_out, o_press_pulse, o_release_pulse, o_long_pulse, o_repeat_pulse};

  int checks = 0;
  int failures = 0;

  // Reference model: sampled-input history, window rule for the clean level,
  // tick arithmetic since the press edge for long/repeat.
  logic [N_CH-1:0] hist[$];
  logic [N_CH-1:0] m_out, m_press, m_rel, m_long, m_rep;
  int              m_n;
  int              m_p[N_CH];
  bit              m_held[N_CH];

  function automatic logic [5*N_CH-1:0] exp_vec();
    return {m_out, m_press, m_rel, m_long, m_rep};
  endfunction

  task automatic model_edge(input logic r, input logic [N_CH-1:0] sw);
    logic [N_CH-1:0] nxt;
    bit   same;
    logic v;
    int   k;
    if (r) begin
      hist.delete();
      for (int i = 0; i < HLEN; i++) hist.push_back(ALL_IDLE);
      m_out = ALL_IDLE;
      m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
      m_n = 0;
      for (int c = 0; c < N_CH; c++) m_held[c] = 0;
    end else begin
      m_n++;
      hist.push_back(sw);
      void'(hist.pop_front());
      nxt = m_out;
      for (int c = 0; c < N_CH; c++) begin
        v = hist[HLEN-1-3][c];
        same = 1;
        for (int j = 3; j <= 3 + DB; j++) if (hist[HLEN-1-j][c] != v) same = 0;
        if (same) nxt[c] = v;
      end
      for (int c = 0; c < N_CH; c++) begin
        m_press[c] = (nxt[c] != IDLE) && (m_out[c] == IDLE);
        m_rel[c]   = (nxt[c] == IDLE) && (m_out[c] != IDLE);
        m_long[c]  = 1'b0;
        m_rep[c]   = 1'b0;
        if (m_press[c]) begin
          m_held[c] = 1;
          m_p[c] = m_n;
        end else if (nxt[c] == IDLE) begin
          m_held[c] = 0;
        end else if (m_held[c] && (m_n % TD == 0)) begin
          k = m_n / TD - m_p[c] / TD;
          m_long[c] = (k == LT);
          m_rep[c]  = (RT > 0) && (k > LT) && ((k - LT) % RT == 0);
        end
      end
      m_out = nxt;
    end
  endtask

  task automatic cyc(input logic r, input logic [N_CH-1:0] sw);
    i_rst = r;
    i_sw_in = sw;
    @(posedge clk);
    model_edge(r, sw);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, ALL_IDLE);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'b0000);
      checks++;
      if (obs !== RESET_VEC) begin
        failures++;
        $display("FAIL reset cyc%0d: got %h want %h", i, obs, RESET_VEC);
      end
    end
    settle(DB + 6);
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL reset_idle: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_clean_press();
    logic [N_CH-1:0] sw;
    int first, nrel;
    sw = ALL_IDLE; sw[0] = 1'b0; first = -1;
    for (int e = 0; e <= DB + 8; e++) begin
      cyc(1'b0, sw);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL clean_press e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (o_press_pulse[0] && first < 0) first = e;
    end
    checks++;
    if (first != DB + 3) begin
      failures++;
      $display("FAIL clean_press_latency: got %0d want %0d", first, DB + 3);
    end
    nrel = 0;
    for (int e = 0; e <= DB + 6; e++) begin
      cyc(1'b0, ALL_IDLE);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL clean_release e%0d: got %h want %h", e, obs, exp_vec());
      end
      nrel += int'(o_release_pulse[0]);
    end
    checks++;
    if (nrel != 1 || o_sw_out[0] !== IDLE) begin
      failures++;
      $display("FAIL clean_release_count: got %0d/%b want 1/%b", nrel, o_sw_out[0], IDLE);
    end
  endtask

  task automatic test_chatter();
    logic [N_CH-1:0] sw;
    int first, npress, nrel;
    sw = ALL_IDLE; first = -1; npress = 0; nrel = 0;
    for (int s = 0; s < 6; s++) begin
      sw[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 5; k++) begin
        cyc(1'b0, sw);
        checks++;
        if (obs !== exp_vec()) begin
          failures++;
          $display("FAIL chatter_toggle s%0d: got %h want %h", s, obs, exp_vec());
        end
        npress += int'(o_press_pulse[1]);
        nrel += int'(o_release_pulse[1]);
      end
    end
    sw[1] = 1'b0;
    for (int e = 0; e <= DB + 8; e++) begin
      cyc(1'b0, sw);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL chatter_hold e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (o_press_pulse[1] && first < 0) first = e;
      npress += int'(o_press_pulse[1]);
      nrel += int'(o_release_pulse[1]);
    end
    checks++;
    if (npress != 1 || nrel != 0 || first != DB + 3) begin
      failures++;
      $display("FAIL chatter_pulses: got p%0d r%0d at %0d want p1 r0 at %0d", npress, nrel, first, DB + 3);
    end
    settle(DB + 6);
  endtask

  task automatic test_long_repeat();
    logic [N_CH-1:0] sw;
    int p, l, nlong, last_rep, nrep, bad_gap, rep_after;
    sw = ALL_IDLE; sw[0] = 1'b0;
    p = -1; l = -1; nlong = 0; last_rep = -1; nrep = 0; bad_gap = 0; rep_after = 0;
    for (int e = 0; e < DB + 3 + 60; e++) begin
      cyc(1'b0, sw);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL long_hold e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (o_press_pulse[0]) p = e;
      if (o_long_pulse[0]) begin nlong++; l = e; last_rep = e; end
      if (o_repeat_pulse[0]) begin
        nrep++;
        if (e - last_rep != RT * TD) bad_gap++;
        last_rep = e;
      end
    end
    checks++;
    if (nlong != 1 || l - p < (LT - 1) * TD + 1 || l - p > LT * TD) begin
      failures++;
      $display("FAIL long_timing: got n%0d delta %0d want n1 delta %0d..%0d", nlong, l - p, (LT - 1) * TD + 1, LT * TD);
    end
    checks++;
    if (nrep < 4 || bad_gap != 0) begin
      failures++;
      $display("FAIL repeat_period: got n%0d badgap %0d want n>=4 badgap 0", nrep, bad_gap);
    end
    for (int e = 0; e <= DB + 3 + 3 * TD; e++) begin
      cyc(1'b0, ALL_IDLE);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL long_release e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (e >= DB + 3) rep_after += int'(o_repeat_pulse[0]) + int'(o_long_pulse[0]);
    end
    checks++;
    if (rep_after != 0) begin
      failures++;
      $display("FAIL repeat_after_release: got %0d want 0", rep_after);
    end
  endtask

  task automatic test_multi();
    logic [N_CH-1:0] sw;
    int p0, p2, nlong2, quiet_bad;
    sw = ALL_IDLE; sw[0] = 1'b0; sw[2] = 1'b0;
    p0 = -1; p2 = -2; nlong2 = 0; quiet_bad = 0;
    for (int e = 0; e < DB + 3 + 30; e++) begin
      if (e == DB + 3 + 4) sw[0] = 1'b1;
      cyc(1'b0, sw);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL multi e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (o_press_pulse[0]) p0 = e;
      if (o_press_pulse[2]) p2 = e;
      nlong2 += int'(o_long_pulse[2]);
      if (o_sw_out[1] !== IDLE || o_sw_out[3] !== IDLE) quiet_bad++;
      if (o_press_pulse[1] || o_press_pulse[3] || o_long_pulse[1] || o_long_pulse[3]) quiet_bad++;
    end
    checks++;
    if (p0 != p2 || nlong2 != 1 || quiet_bad != 0) begin
      failures++;
      $display("FAIL multi_summary: got p0=%0d p2=%0d long2=%0d quiet=%0d want equal,1,0", p0, p2, nlong2, quiet_bad);
    end
    settle(DB + 6);
  endtask

  task automatic test_reset_mid_hold();
    logic [N_CH-1:0] sw;
    int first;
    sw = ALL_IDLE; sw[0] = 1'b0; first = -1;
    for (int e = 0; e < DB + 3 + 3; e++) cyc(1'b0, sw);
    checks++;
    if (o_sw_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_hold_pressed: got %b want 0", o_sw_out[0]);
    end
    cyc(1'b1, sw);
    checks++;
    if (obs !== RESET_VEC) begin
      failures++;
      $display("FAIL mid_hold_reset: got %h want %h", obs, RESET_VEC);
    end
    cyc(1'b1, sw);
    for (int e = 0; e <= DB + 8; e++) begin
      cyc(1'b0, sw);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL after_reset e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (o_press_pulse[0] && first < 0) first = e;
    end
    checks++;
    if (first != DB + 3) begin
      failures++;
      $display("FAIL after_reset_latency: got %0d want %0d", first, DB + 3);
    end
    settle(DB + 6);
  endtask

  task automatic test_short_pulse();
    logic [N_CH-1:0] sw;
    int bad;
    bad = 0;
    for (int e = 0; e < 8 + DB + 6; e++) begin
      sw = ALL_IDLE;
      if (e < 8) sw[3] = 1'b0;
      cyc(1'b0, sw);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL short_pulse e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (o_sw_out[3] !== IDLE || o_press_pulse[3] || o_release_pulse[3]) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL short_pulse_leak: got %0d want 0", bad);
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] sw;
    logic r;
    int dwell[N_CH];
    sw = ALL_IDLE;
    for (int c = 0; c < N_CH; c++) dwell[c] = $urandom_range(1, 40);
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (dwell[c] == 0) begin
          sw[c] = ~sw[c];
          dwell[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : $urandom_range(10, 70);
        end else begin
          dwell[c]--;
        end
      end
      r = ($urandom_range(0, 399) == 0);
      cyc(r, sw);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random n%0d: got %h want %h", n, obs, exp_vec());
      end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_sw_in = ALL_IDLE;
    test_reset();
    test_clean_press();
    test_chatter();
    test_long_repeat();
    test_multi();
    test_reset_mid_hold();
    test_short_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
